// File: rtl/pipe_regs.sv
// pipe_regs: F/D/E pipeline registers with stall/bubble control and synchronous active-low reset.
// Define PIPE_REGS_PERF_CNT_EN to add saturating stall_cnt/bubble_cnt performance counters.
module pipe_regs #(
  parameter logic [3:0] NOP_ICODE = 4'h1,
  parameter logic [3:0] RNONE     = 4'hF,
  parameter logic [3:0] SAOK      = 4'h1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        F_stall,
  input  logic        D_stall,
  input  logic        D_bubble,
  input  logic        E_bubble,
  input  logic [63:0] f_predPC,
  input  logic [3:0]  f_stat,
  input  logic [3:0]  f_icode,
  input  logic [3:0]  f_ifun,
  input  logic [3:0]  f_rA,
  input  logic [3:0]  f_rB,
  input  logic [63:0] f_valC,
  input  logic [63:0] f_valP,
  input  logic [3:0]  d_stat,
  input  logic [3:0]  d_icode,
  input  logic [3:0]  d_ifun,
  input  logic [3:0]  d_dstE,
  input  logic [3:0]  d_dstM,
  input  logic [3:0]  d_srcA,
  input  logic [3:0]  d_srcB,
  input  logic [63:0] d_valC,
  input  logic [63:0] d_valA,
  input  logic [63:0] d_valB,
  output logic [63:0] F_predPC,
  output logic [3:0]  D_stat,
  output logic [3:0]  D_icode,
  output logic [3:0]  D_ifun,
  output logic [3:0]  D_rA,
  output logic [3:0]  D_rB,
  output logic [63:0] D_valC,
  output logic [63:0] D_valP,
  output logic [3:0]  E_stat,
  output logic [3:0]  E_icode,
  output logic [3:0]  E_ifun,
  output logic [3:0]  E_dstE,
  output logic [3:0]  E_dstM,
  output logic [3:0]  E_srcA,
  output logic [3:0]  E_srcB,
  output logic [63:0] E_valC,
  output logic [63:0] E_valA,
  output logic [63:0] E_valB
`ifdef PIPE_REGS_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] bubble_cnt
`endif
);
  typedef struct packed {
    logic [3:0]  stat;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [63:0] valc;
    logic [63:0] valp;
  } d_reg_t;
  typedef struct packed {
    logic [3:0]  stat;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  dste;
    logic [3:0]  dstm;
    logic [3:0]  srca;
    logic [3:0]  srcb;
    logic [63:0] valc;
    logic [63:0] vala;
    logic [63:0] valb;
  } e_reg_t;
  localparam d_reg_t D_BUB = '{stat: SAOK, icode: NOP_ICODE, ifun: 4'h0, ra: RNONE, rb: RNONE,
                               valc: 64'd0, valp: 64'd0};
  localparam e_reg_t E_BUB = '{stat: SAOK, icode: NOP_ICODE, ifun: 4'h0, dste: RNONE, dstm: RNONE,
                               srca: RNONE, srcb: RNONE, valc: 64'd0, vala: 64'd0, valb: 64'd0};
  logic [63:0] f_pc_d, f_pc_q;
  d_reg_t      d_reg_d, d_reg_q, f_in;
  e_reg_t      e_reg_d, e_reg_q, d_in;
  always_comb begin
    f_in    = '{stat: f_stat, icode: f_icode, ifun: f_ifun, ra: f_rA, rb: f_rB,
                valc: f_valC, valp: f_valP};
    d_in    = '{stat: d_stat, icode: d_icode, ifun: d_ifun, dste: d_dstE, dstm: d_dstM,
                srca: d_srcA, srcb: d_srcB, valc: d_valC, vala: d_valA, valb: d_valB};
    f_pc_d  = F_stall ? f_pc_q : f_predPC;
    // a stall wins over a simultaneous bubble request on D
    d_reg_d = D_stall ? d_reg_q : (D_bubble ? D_BUB : f_in);
    e_reg_d = E_bubble ? E_BUB : d_in;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      f_pc_q  <= 64'd0;
      d_reg_q <= D_BUB;
      e_reg_q <= E_BUB;
    end else begin
      f_pc_q  <= f_pc_d;
      d_reg_q <= d_reg_d;
      e_reg_q <= e_reg_d;
    end
  end
  assign F_predPC = f_pc_q;
  assign D_stat   = d_reg_q.stat;
  assign D_icode  = d_reg_q.icode;
  assign D_ifun   = d_reg_q.ifun;
  assign D_rA     = d_reg_q.ra;
  assign D_rB     = d_reg_q.rb;
  assign D_valC   = d_reg_q.valc;
  assign D_valP   = d_reg_q.valp;
  assign E_stat   = e_reg_q.stat;
  assign E_icode  = e_reg_q.icode;
  assign E_ifun   = e_reg_q.ifun;
  assign E_dstE   = e_reg_q.dste;
  assign E_dstM   = e_reg_q.dstm;
  assign E_srcA   = e_reg_q.srca;
  assign E_srcB   = e_reg_q.srcb;
  assign E_valC   = e_reg_q.valc;
  assign E_valA   = e_reg_q.vala;
  assign E_valB   = e_reg_q.valb;
`ifdef PIPE_REGS_PERF_CNT_EN
  logic [31:0] stall_cnt_d, stall_cnt_q, bubble_cnt_d, bubble_cnt_q;
  logic        bubble_ev;
  always_comb begin
    // a D bubble overridden by a stall is not a bubble; double bubbles count once
    bubble_ev    = (D_bubble & ~D_stall) | E_bubble;
    stall_cnt_d  = (D_stall && stall_cnt_q != '1) ? stall_cnt_q + 32'd1 : stall_cnt_q;
    bubble_cnt_d = (bubble_ev && bubble_cnt_q != '1) ? bubble_cnt_q + 32'd1 : bubble_cnt_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q  <= 32'd0;
      bubble_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end
  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`endif
endmodule

// File: tb/tb_pipe_regs.sv
// tb_pipe_regs: randomized self-checking bench for pipe_regs against a rule-level reference model.
module tb_pipe_regs;
  logic        clk = 1'b0;
  logic        rst_n, F_stall, D_stall, D_bubble, E_bubble;
  logic [63:0] f_predPC, f_valC, f_valP, d_valC, d_valA, d_valB;
  logic [3:0]  f_stat, f_icode, f_ifun, f_rA, f_rB;
  logic [3:0]  d_stat, d_icode, d_ifun, d_dstE, d_dstM, d_srcA, d_srcB;
  logic [63:0] F_predPC, D_valC, D_valP, E_valC, E_valA, E_valB;
  logic [3:0]  D_stat, D_icode, D_ifun, D_rA, D_rB;
  logic [3:0]  E_stat, E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB;
`ifdef PIPE_REGS_PERF_CNT_EN
  logic [31:0] stall_cnt, bubble_cnt;
`endif
  int checks = 0, failures = 0;
  localparam logic [147:0] D_BUB = {4'h1, 4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'd0};
  localparam logic [219:0] E_BUB = {4'h1, 4'h1, 4'h0, 4'hF, 4'hF, 4'hF, 4'hF, 64'd0, 64'd0, 64'd0};
  logic [63:0]  exp_pc;
  logic [147:0] exp_d;
  logic [219:0] exp_e;
  logic [31:0]  exp_sc, exp_bc;
  wire  [147:0] dut_d = {D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP};
  wire  [219:0] dut_e = {E_stat, E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB, E_valC, E_valA, E_valB};
  wire  [147:0] f_vec = {f_stat, f_icode, f_ifun, f_rA, f_rB, f_valC, f_valP};
  wire  [219:0] d_vec = {d_stat, d_icode, d_ifun, d_dstE, d_dstM, d_srcA, d_srcB, d_valC, d_valA, d_valB};

  pipe_regs dut (
    .clk(clk), .rst_n(rst_n), .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble), .E_bubble(E_bubble),
    .f_predPC(f_predPC), .f_stat(f_stat), .f_icode(f_icode), .f_ifun(f_ifun), .f_rA(f_rA), .f_rB(f_rB),
    .f_valC(f_valC), .f_valP(f_valP), .d_stat(d_stat), .d_icode(d_icode), .d_ifun(d_ifun),
    .d_dstE(d_dstE), .d_dstM(d_dstM), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .d_valC(d_valC), .d_valA(d_valA), .d_valB(d_valB), .F_predPC(F_predPC),
    .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB),
    .D_valC(D_valC), .D_valP(D_valP), .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
    .E_dstE(E_dstE), .E_dstM(E_dstM), .E_srcA(E_srcA), .E_srcB(E_srcB),
    .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB)
`ifdef PIPE_REGS_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic rand_data();
    f_predPC = {$urandom, $urandom}; f_valC = {$urandom, $urandom}; f_valP = {$urandom, $urandom};
    d_valC = {$urandom, $urandom}; d_valA = {$urandom, $urandom}; d_valB = {$urandom, $urandom};
    {f_stat, f_icode, f_ifun, f_rA, f_rB} = 20'($urandom);
    {d_stat, d_icode, d_ifun, d_dstE, d_dstM, d_srcA, d_srcB} = 28'($urandom);
  endtask

  task automatic set_ctl(input logic fs, input logic ds, input logic db, input logic eb);
    F_stall = fs; D_stall = ds; D_bubble = db; E_bubble = eb;
  endtask

  // Glitch the controls mid-cycle, then advance the model from the values present at the edge.
  task automatic tick();
    logic [3:0] ctl;
    ctl = {F_stall, D_stall, D_bubble, E_bubble};
    {F_stall, D_stall, D_bubble, E_bubble} = ~ctl;
    #1;
    {F_stall, D_stall, D_bubble, E_bubble} = ctl;
    if (!rst_n) begin
      exp_pc = 0; exp_d = D_BUB; exp_e = E_BUB; exp_sc = 0; exp_bc = 0;
    end else begin
      if (!F_stall) exp_pc = f_predPC;
      if (!D_stall) exp_d = D_bubble ? D_BUB : f_vec;
      exp_e = E_bubble ? E_BUB : d_vec;
      if (D_stall && exp_sc != 32'hFFFF_FFFF) exp_sc = exp_sc + 1;
      if (((D_bubble && !D_stall) || E_bubble) && exp_bc != 32'hFFFF_FFFF) exp_bc = exp_bc + 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    for (int i = 0; i < 2; i++) begin
      rand_data();
      set_ctl(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      tick();
    end
    checks++; if (F_predPC !== 64'd0) begin failures++; $display("FAIL reset_pc got=%h exp=0", F_predPC); end
    checks++; if ({D_icode, E_icode, D_stat, E_stat} !== 16'h1111) begin
      failures++; $display("FAIL reset_icode_stat got=%h exp=1111", {D_icode, E_icode, D_stat, E_stat}); end
    checks++; if ({E_dstE, E_dstM} !== 8'hFF) begin failures++; $display("FAIL reset_dst got=%h exp=ff", {E_dstE, E_dstM}); end
    checks++; if (dut_d !== D_BUB || dut_e !== E_BUB) begin failures++; $display("FAIL reset_regs d=%h e=%h", dut_d, dut_e); end
`ifdef PIPE_REGS_PERF_CNT_EN
    checks++; if ({stall_cnt, bubble_cnt} !== 64'd0) begin
      failures++; $display("FAIL reset_cnt got=%h/%h exp=0/0", stall_cnt, bubble_cnt); end
`endif
  endtask

  task automatic test_pass_through();
    rst_n = 1; rand_data(); set_ctl(0, 0, 0, 0);
    f_predPC = 64'h100; f_icode = 4'd3; d_valA = 64'h55;
    tick();
    checks++; if (F_predPC !== 64'h100) begin failures++; $display("FAIL pass_pc got=%h exp=100", F_predPC); end
    checks++; if (D_icode !== 4'd3) begin failures++; $display("FAIL pass_dicode got=%h exp=3", D_icode); end
    checks++; if (E_valA !== 64'h55) begin failures++; $display("FAIL pass_evala got=%h exp=55", E_valA); end
    checks++; if (dut_d !== exp_d || dut_e !== exp_e) begin failures++; $display("FAIL pass_regs d=%h e=%h", dut_d, dut_e); end
  endtask

  task automatic test_load_use();
    logic [63:0]  pc0;
    logic [147:0] d0;
    pc0 = F_predPC; d0 = dut_d;
    rand_data(); set_ctl(1, 1, 0, 1);
    tick();
    checks++; if (F_predPC !== pc0) begin failures++; $display("FAIL lu_pc got=%h exp=%h", F_predPC, pc0); end
    checks++; if (dut_d !== d0) begin failures++; $display("FAIL lu_d got=%h exp=%h", dut_d, d0); end
    checks++; if ({E_icode, E_dstM} !== 8'h1F) begin failures++; $display("FAIL lu_e got=%h exp=1f", {E_icode, E_dstM}); end
`ifdef PIPE_REGS_PERF_CNT_EN
    checks++; if ({stall_cnt, bubble_cnt} !== {32'd1, 32'd1}) begin
      failures++; $display("FAIL lu_cnt got=%0d/%0d exp=1/1", stall_cnt, bubble_cnt); end
`endif
    set_ctl(0, 0, 0, 0);
  endtask

  task automatic test_mispredict();
    logic [31:0] bc0;
    bc0 = exp_bc;
    rand_data(); f_icode = 4'd6; d_icode = 4'd2; set_ctl(0, 0, 1, 1);
    tick();
    checks++; if ({D_icode, E_icode} !== 8'h11) begin failures++; $display("FAIL mp_icode got=%h exp=11", {D_icode, E_icode}); end
    checks++; if (F_predPC !== f_predPC) begin failures++; $display("FAIL mp_pc got=%h exp=%h", F_predPC, f_predPC); end
`ifdef PIPE_REGS_PERF_CNT_EN
    checks++; if (bubble_cnt !== bc0 + 32'd1) begin failures++; $display("FAIL mp_bcnt got=%0d exp=%0d", bubble_cnt, bc0 + 1); end
`endif
    set_ctl(0, 0, 0, 0);
  endtask

  task automatic test_conflict_reset();
    logic [147:0] d0;
    logic [63:0]  pc0;
    rand_data(); set_ctl(0, 0, 0, 0); tick();
    d0 = dut_d;
    rand_data(); set_ctl(0, 1, 1, 0); tick();
    checks++; if (dut_d !== d0) begin failures++; $display("FAIL conflict_hold got=%h exp=%h", dut_d, d0); end
    pc0 = F_predPC; rst_n = 0; #1;
    checks++; if (dut_d !== d0 || F_predPC !== pc0) begin failures++; $display("FAIL rst_async d=%h pc=%h", dut_d, F_predPC); end
    for (int i = 0; i < 3; i++) begin rand_data(); set_ctl(1, 1, 0, 0); tick(); end
    checks++; if (dut_d !== D_BUB || F_predPC !== 64'd0) begin failures++; $display("FAIL rst_stall d=%h pc=%h", dut_d, F_predPC); end
    rst_n = 1; rand_data(); set_ctl(0, 0, 0, 0); tick();
    checks++; if (dut_d !== f_vec) begin failures++; $display("FAIL rst_resume got=%h exp=%h", dut_d, f_vec); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      rst_n = ($urandom_range(0, 19) != 0);
      rand_data();
      set_ctl(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      tick();
      checks++;
      if (F_predPC !== exp_pc || dut_d !== exp_d || dut_e !== exp_e) begin
        failures++; $display("FAIL rand_regs cyc=%0d pc=%h/%h d_ok=%0b e_ok=%0b", i, F_predPC, exp_pc, dut_d === exp_d, dut_e === exp_e);
      end
`ifdef PIPE_REGS_PERF_CNT_EN
      checks++;
      if (stall_cnt !== exp_sc || bubble_cnt !== exp_bc) begin
        failures++; $display("FAIL rand_cnt cyc=%0d got=%0d/%0d exp=%0d/%0d", i, stall_cnt, bubble_cnt, exp_sc, exp_bc);
      end
`endif
    end
    rst_n = 1;
  endtask

`ifdef PIPE_REGS_PERF_CNT_EN
  task automatic test_saturation();
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt_q;
    exp_sc = 32'hFFFF_FFFE;
    for (int i = 0; i < 3; i++) begin rand_data(); set_ctl(0, 1, 0, 0); tick(); end
    checks++; if (stall_cnt !== 32'hFFFF_FFFF) begin failures++; $display("FAIL sat_stall got=%h exp=ffffffff", stall_cnt); end
  endtask
`endif

  initial begin
    rst_n = 0; set_ctl(0, 0, 0, 0); rand_data();
    exp_pc = 0; exp_d = D_BUB; exp_e = E_BUB; exp_sc = 0; exp_bc = 0;
    @(posedge clk); #1;
    test_reset();
    test_pass_through();
    test_load_use();
    test_mispredict();
    test_conflict_reset();
    test_random();
`ifdef PIPE_REGS_PERF_CNT_EN
    test_saturation();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipe_regs.md
PIPE_REGS -- requirements
Module: pipe_regs

Interface
REQ-001 Parameter NOP_ICODE, default 4'h1, icode inserted by a bubble.
REQ-002 Parameter RNONE, default 4'hF, register ID inserted by a bubble for dstE/dstM/srcA/srcB.
REQ-003 Parameter SAOK, default 4'h1, stat code inserted by a bubble and by reset.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 F_stall, D_stall, D_bubble, E_bubble  in  1 each  pipeline control requests from the stall/bubble controller.
REQ-007 f_predPC  in  64  predicted PC from fetch.
REQ-008 f_stat, f_icode, f_ifun, f_rA, f_rB  in  4 each  fetch-stage fields.
REQ-009 f_valC, f_valP  in  64 each  fetch-stage constant and next PC.
REQ-010 d_stat, d_icode, d_ifun, d_dstE, d_dstM, d_srcA, d_srcB  in  4 each  decode-stage fields.
REQ-011 d_valC, d_valA, d_valB  in  64 each  decode-stage values.
REQ-012 F_predPC  out  64  F register.
REQ-013 D_stat, D_icode, D_ifun, D_rA, D_rB  out  4 each; D_valC, D_valP  out  64 each  D register.
REQ-014 E_stat, E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB  out  4 each; E_valC, E_valA, E_valB  out  64 each  E register.
REQ-015 stall_cnt, bubble_cnt  out  32 each  performance counters (present only per REQ-029).

Function
REQ-016 All outputs SHALL be registered, with no combinational path from inputs to outputs; the latency from input to output SHALL be 1 cycle.
REQ-017 F register: F_stall=0 SHALL load f_predPC; F_stall=1 SHALL hold F_predPC.
REQ-018 D register, D_stall=1: all D fields SHALL hold, regardless of D_bubble.
REQ-019 D register, D_stall=0 and D_bubble=1: the register SHALL load the bubble: D_stat=SAOK, D_icode=NOP_ICODE, D_ifun=0, D_rA=D_rB=RNONE, D_valC=D_valP=0.
REQ-020 D register, D_stall=0 and D_bubble=0: all D fields SHALL load the corresponding f_* inputs.
REQ-021 E register, E_bubble=1: the register SHALL load the bubble: E_stat=SAOK, E_icode=NOP_ICODE, E_ifun=0, E_dstE=E_dstM=E_srcA=E_srcB=RNONE, E_valC=E_valA=E_valB=0.
REQ-022 E register, E_bubble=0: all E fields SHALL load the corresponding d_* inputs; the E register has no stall.
REQ-023 Simultaneous events: F_stall, D_stall and E_bubble SHALL act independently in the same cycle. Example: a load-use hazard (F_stall=D_stall=E_bubble=1) holds F and D and bubbles E.
REQ-024 The illegal combination D_stall=1 with D_bubble=1 SHALL be resolved as a stall, with no error flag.
REQ-025 Control inputs SHALL be sampled only at the clock edge; glitches between edges SHALL have no effect.

Reset
REQ-026 rst_n=0 at a rising edge SHALL force, overriding all stall and bubble inputs: F_predPC=0, D register=bubble value, E register=bubble value, and counters=0 when present.
REQ-027 Reset asserted mid-stall SHALL discard any held contents; the first edge after rst_n returns to 1 SHALL resume normal loading.
REQ-028 rst_n SHALL have no asynchronous effect; outputs SHALL stay unchanged until the next rising edge.

Configuration
REQ-029 Macro PIPE_REGS_PERF_CNT_EN defined: stall_cnt SHALL increment by 1 on each non-reset edge with D_stall=1.
REQ-030 Macro PIPE_REGS_PERF_CNT_EN defined: bubble_cnt SHALL increment by 1 on each non-reset edge with (D_bubble & ~D_stall) | E_bubble, counting a double bubble once.
REQ-031 Both counters SHALL saturate at 32'hFFFF_FFFF and never wrap.
REQ-032 Macro PIPE_REGS_PERF_CNT_EN undefined: the stall_cnt and bubble_cnt ports and all counter logic SHALL be absent, with all other behaviour unchanged.

Verification
REQ-033 Reset: hold rst_n=0 for 2 cycles with random inputs -> F_predPC=0, D_icode=E_icode=1, D_stat=E_stat=1, E_dstE=E_dstM=4'hF, counters=0.
REQ-034 Pass-through: f_predPC=0x100, f_icode=3, d_valA=0x55, all controls 0 -> next cycle F_predPC=0x100, D_icode=3, E_valA=0x55.
REQ-035 Load-use: F_stall=D_stall=E_bubble=1 for 1 cycle with new f_*/d_* values -> F and D unchanged, E_icode=1, E_dstM=4'hF; stall_cnt=1, bubble_cnt=1 when enabled.
REQ-036 Mispredict: D_bubble=E_bubble=1 with f_icode=6, d_icode=2 -> D_icode=1, E_icode=1, F_predPC loads f_predPC; bubble_cnt increments by exactly 1.
REQ-037 Conflict plus reset: D_stall=D_bubble=1 -> D holds; then rst_n=0 during a 3-cycle stall -> D becomes the bubble value; after reset release, D loads f_* on the first edge.
REQ-038 Saturation (macro defined): preload stall_cnt near 32'hFFFF_FFFE and apply 3 stall cycles -> stall_cnt=32'hFFFF_FFFF with no wrap.
